// File: rtl/mac_driver.sv
// rtl/mac_driver.sv - Operand driver for a fixed-latency MAC with a credit-limited, tagged result FIFO.
module mac_driver #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [3:0] in_coef,
  output logic [3:0] mac_ina,
  output logic [3:0] mac_inb,
  output logic [3:0] mac_coef,
  input  logic [7:0] mac_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [1:0] res_tag,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 2);
  localparam int OW = $clog2(DEPTH + LAT + 2);

  logic [LAT:0]  r_vld;
  logic [1:0]    r_tagp [0:LAT];
  logic [1:0]    r_tag;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [9:0]    r_mem [0:DEPTH-1];

  logic          w_acc;
  logic          w_wr;
  logic          w_pop;
  logic [IW-1:0] w_inflight;
  logic [OW-1:0] w_occ;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= LAT; i++) begin
      w_inflight = w_inflight + IW'(r_vld[i]);
    end
  end

  // Credits cover both pipeline and FIFO, so a completing result always has a slot.
  assign w_occ     = OW'(r_count) + OW'(w_inflight);
  assign in_ready  = (w_occ < OW'(DEPTH));
  assign w_acc     = in_valid && in_ready;
  assign w_wr      = r_vld[LAT];
  assign res_valid = (r_count != '0);
  assign w_pop     = res_valid && res_ready;
  assign res_data  = res_valid ? r_mem[r_rd_ptr][7:0] : 8'h00;
  assign res_tag   = res_valid ? r_mem[r_rd_ptr][9:8] : 2'b00;
  assign busy      = (w_inflight != '0) || (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_ina  <= '0;
      mac_inb  <= '0;
      mac_coef <= '0;
      r_tag    <= '0;
      r_vld    <= '0;
      for (int i = 0; i <= LAT; i++) r_tagp[i] <= '0;
    end else begin
      if (w_acc) begin
        mac_ina  <= in_a;
        mac_inb  <= in_b;
        mac_coef <= in_coef;
        r_tag    <= r_tag + 2'd1;
      end
      r_vld[0]  <= w_acc;
      r_tagp[0] <= r_tag;
      for (int i = 1; i <= LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_tagp[i] <= r_tagp[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_tagp[LAT], mac_out};
  end

endmodule

// File: tb/tb_mac_driver.sv
// tb/tb_mac_driver.sv - Directed-vector bench for mac_driver with a behavioural 3-stage MAC.
module tb_mac_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0, in_b = '0, in_coef = '0;
  logic [3:0] mac_ina, mac_inb, mac_coef;
  logic [7:0] mac_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [1:0] res_tag;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mac_driver #(.LAT(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_coef(in_coef),
    .mac_ina(mac_ina), .mac_inb(mac_inb), .mac_coef(mac_coef),
    .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .busy(busy)
  );

  // MAC datapath stand-in: three register stages, never reset, optional garbage.
  logic [7:0] p1, p2, p3, rnd;
  logic       garb = 1'b0;
  always @(posedge clk) begin
    p1  <= {4'b0, mac_ina} * {4'b0, mac_inb} + {3'b0, mac_coef, 1'b0};
    p2  <= p1;
    p3  <= p2;
    rnd <= 8'($urandom);
  end
  assign mac_out = garb ? rnd : p3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] got_d[$];
  logic [1:0] got_t[$];
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      got_d.push_back(res_data);
      got_t.push_back(res_tag);
    end
    if (dut.w_wr) check("no_full_write", 32'(dut.r_count == 4 && !dut.w_pop), 0);
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_d.delete(); got_t.delete();
  endtask

  // Presents a triple and returns 1 ns after the edge that accepts it; in_valid stays high.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int n = 0;
    in_a = a; in_b = b; in_coef = c; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1'b1;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(busy), 0);
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  logic [3:0] sa [10] = '{4'd1, 4'd2, 4'd4, 4'd15, 4'd0, 4'd7, 4'd10, 4'd15, 4'd8, 4'd5};
  logic [3:0] sb [10] = '{4'd1, 4'd3, 4'd4, 4'd1, 4'd9, 4'd7, 4'd12, 4'd15, 4'd2, 4'd13};
  logic [3:0] sc [10] = '{4'd0, 4'd1, 4'd4, 4'd0, 4'd7, 4'd3, 4'd5, 4'd15, 4'd9, 4'd11};
  logic [7:0] se [10] = '{8'd1, 8'd8, 8'd24, 8'd15, 8'd14, 8'd55, 8'd130, 8'd255, 8'd34, 8'd87};

  logic [3:0] ba [5] = '{4'd3, 4'd2, 4'd1, 4'd6, 4'd4};
  logic [3:0] bb [5] = '{4'd5, 4'd2, 4'd0, 4'd6, 4'd3};
  logic [3:0] bc [5] = '{4'd2, 4'd2, 4'd15, 4'd1, 4'd0};
  logic [7:0] be [5] = '{8'h13, 8'd8, 8'd30, 8'd38, 8'd12};

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_tag", 32'(res_tag), 0);
    check("rst_mac_ina", 32'(mac_ina), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single transfer: latency and value.
    @(posedge clk); #1;
    send(4'd3, 4'd5, 4'd2);
    in_valid = 1'b0;
    @(negedge clk);
    check("single_mac_ina", 32'(mac_ina), 3);
    check("single_mac_coef", 32'(mac_coef), 2);
    check("single_busy", 32'(busy), 1);
    check("single_early_k", 32'(res_valid), 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("single_early", 32'(res_valid), 0);
    end
    @(negedge clk);
    check("single_valid_k4", 32'(res_valid), 1);
    check("single_data", 32'(res_data), 32'h13);
    check("single_tag", 32'(res_tag), 0);
    drain();

    // Full-scale operands.
    send(4'd15, 4'd15, 4'd15);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("full_valid", 32'(res_valid), 1);
    check("full_data", 32'(res_data), 32'hFF);
    check("full_tag", 32'(res_tag), 1);
    drain();

    // Back-pressure: four credits, fifth triple held.
    reset_dut();
    for (int i = 0; i < 4; i++) send(ba[i], bb[i], bc[i]);
    in_a = ba[4]; in_b = bb[4]; in_coef = bc[4];
    @(negedge clk);
    check("bp_ready_low", 32'(in_ready), 0);
    repeat (6) @(negedge clk);
    check("bp_ready_held", 32'(in_ready), 0);
    check("bp_valid", 32'(res_valid), 1);
    check("bp_head_data", 32'(res_data), 32'h13);
    check("bp_head_tag", 32'(res_tag), 0);
    check("bp_mac_hold", 32'(mac_ina), 6);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_back", 32'(in_ready), 1);
    check("bp_second_head", 32'(res_data), 8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_fifth_mac", 32'(mac_ina), 4);
    drain();
    check("bp_count", 32'(got_d.size()), 5);
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      check("bp_data", 32'(got_d[i]), 32'(be[i]));
      check("bp_tag", 32'(got_t[i]), 32'(i % 4));
    end

    // Reset with two triples in flight.
    reset_dut();
    send(4'd2, 4'd3, 4'd4);
    send(4'd1, 4'd1, 4'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(in_ready), 1);
    check("mid_rst_mac", 32'(mac_ina), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid_no_stale", 32'(res_valid), 0);
    end
    check("mid_nothing_popped", 32'(got_d.size()), 0);
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Garbage on mac_out while idle.
    garb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("garb_no_write", 32'(res_valid), 0);
    end
    check("garb_busy", 32'(busy), 0);
    @(posedge clk); #1;
    garb = 1'b0;

    // Streaming ten triples with the sink always ready.
    reset_dut();
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(sa[i], sb[i], sc[i]);
    in_valid = 1'b0;
    for (int n = 0; n < 60 && got_d.size() < 10; n++) @(negedge clk);
    check("stream_count", 32'(got_d.size()), 10);
    for (int i = 0; i < 10 && i < got_d.size(); i++) begin
      check("stream_data", 32'(got_d[i]), 32'(se[i]));
      check("stream_tag", 32'(got_t[i]), 32'(i % 4));
    end
    @(negedge clk);
    check("stream_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mac_driver.md
MAC_DRIVER -- requirements
Module: mac_driver

Interface
REQ-001 SHALL have parameter LAT, default 3: edges from mac_* operand update until mac_out holds the result.
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries, which is also the limit on operands accepted but not yet popped.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: upstream operand triple valid.
REQ-006 SHALL have port in_ready, output, 1: driver can accept a triple this cycle.
REQ-007 SHALL have ports in_a, in_b, in_coef, input, 4 each: unsigned operands.
REQ-008 SHALL have ports mac_ina, mac_inb, mac_coef, output, 4 each: registered operands to the MAC datapath.
REQ-009 SHALL have port mac_out, input, 8: MAC result, equal to ina*inb + 2*coef, LAT edges after the operands are applied.
REQ-010 SHALL have port res_valid, output, 1: FIFO head valid.
REQ-011 SHALL have port res_ready, input, 1: downstream accepts the head.
REQ-012 SHALL have port res_data, output, 8: result at the FIFO head.
REQ-013 SHALL have port res_tag, output, 2: sequence tag of the head result.
REQ-014 SHALL have port busy, output, 1: results in flight or FIFO not empty.

Function
REQ-015 SHALL accept a triple at a rising edge only when in_valid && in_ready; call that edge k.
REQ-016 SHALL load mac_ina/mac_inb/mac_coef at edge k; with no accept they SHALL hold their last values.
REQ-017 SHALL track accepted triples with a valid/tag shift pipeline of LAT+1 stages, advanced every edge regardless of handshakes.
REQ-018 SHALL write mac_out and the tag into the FIFO at edge k+LAT+1; with LAT=3 that is edge k+4, so res_valid is high from edge k+4 if the FIFO was empty.
REQ-019 SHALL discard mac_out values on cycles with no tracked triple completing.
REQ-020 SHALL drive in_ready = (fifo_count + inflight_count) < DEPTH, combinationally from registered state only, with no dependence on in_valid or res_ready.
REQ-021 SHALL therefore never drop a completing result; a FIFO write when full is impossible by construction, and the bench SHALL assert this.
REQ-022 SHALL drive res_valid = (fifo_count != 0); res_data and res_tag SHALL be the head entry and SHALL be held stable while res_valid && !res_ready.
REQ-023 SHALL pop the head at an edge where res_valid && res_ready.
REQ-024 SHALL handle a simultaneous FIFO write and pop in the same edge, leaving fifo_count unchanged; this SHALL also hold when the FIFO is full, since the pop frees the slot.
REQ-025 SHALL handle a simultaneous accept and completion in the same edge, both counted.
REQ-026 SHALL assign tags from a 2-bit counter that increments on each accept, starts at 0 and wraps 3->0.
REQ-027 SHALL return results in acceptance order.
REQ-028 SHALL take the 8-bit result from mac_out unmodified; the maximum value 15*15+2*15 = 255 fits with no overflow handling.
REQ-029 SHALL drive busy = (inflight_count != 0) || (fifo_count != 0).

Reset
REQ-030 SHALL, while rst_n = 0, clear mac_ina/mac_inb/mac_coef to 0, the valid pipeline, the FIFO pointers and count, and the tag counter.
REQ-031 SHALL hold res_valid = 0, busy = 0, res_data = 0 and res_tag = 0 while rst_n = 0, and in_ready = 1 immediately.
REQ-032 SHALL discard any in-flight and buffered results on reset mid-operation; results the MAC emits after release SHALL NOT be captured.

Verification
REQ-033 SHALL cover a single transfer: a=3, b=5, coef=2 accepted at edge k -> res_valid rises at edge k+4 with res_data=0x13 and res_tag=0.
REQ-034 SHALL cover a full-scale transfer: a=15, b=15, coef=15 -> res_data=0xFF.
REQ-035 SHALL cover back-pressure: res_ready=0 with 4 consecutive accepts -> in_ready=0 from the edge after the 4th accept, a 5th in_valid is held, res_data holds the first result; res_ready=1 for one cycle -> in_ready=1 the next cycle.
REQ-036 SHALL cover streaming: res_ready=1, in_valid=1 continuously for 10 triples -> one accept per cycle, in-order results, tags 0,1,2,3,0,1,...
REQ-037 SHALL cover reset mid-flight: 2 triples in flight, rst_n pulsed low -> res_valid stays 0, busy=0, and no stale result appears within 8 cycles.
REQ-038 SHALL cover mac_out garbage: random mac_out values on idle cycles -> no FIFO writes.
